// File: rtl/score_display_pkg.sv
// score_display_pkg: segment constants, FSM encoding and overflow-limit helper for the score display
package score_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic longint unsigned pow10(input int n);
      pow10 = 1;
      for (int k = 0; k < n; k++) pow10 = pow10 * 10;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: one BCD digit to active-low 7-segment pattern (bit0=a .. bit6=g)
module bcd_to_7seg
   import score_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      case (digit)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_display_driver.sv
// score_display_driver: sequential double-dabble binary-to-BCD conversion driving
// active-low HEX displays with leading-zero blanking, overflow dashes and blink.
module score_display_driver
   import score_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_WIDTH  = 14,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [BIN_WIDTH-1:0]    value,
   input  logic                    load,
   output logic                    ready,
   input  logic                    blank_leading,
   input  logic                    blink_en,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] segments
);

   localparam int BW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(BIN_WIDTH + 1);
   localparam int DW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam longint unsigned LIMIT = pow10(NUM_DIGITS);

   state_t                  state, state_next;
   logic [BIN_WIDTH-1:0]    bin;
   logic [BW-1:0]           bcd, bcd_adj, digits;
   logic [CW-1:0]           cnt;
   logic                    ovf_pend;
   logic [DW-1:0]           blink_cnt;
   logic                    phase;
   logic                    accept, last;
   logic [BW+BIN_WIDTH-1:0] shifted;

   assign accept  = load && ready;
   assign last    = state == ST_SHIFT && cnt == CW'(1);
   assign shifted = {bcd_adj, bin} << 1;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state == ST_IDLE ? (load ? ST_SHIFT : ST_IDLE)
                                    : (cnt == CW'(1) ? ST_IDLE : ST_SHIFT);
   end

   always_comb begin
      ready = state == ST_IDLE;
   end

   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < NUM_DIGITS; k++)
         bcd_adj[4*k +: 4] = bcd[4*k +: 4] >= 4'd5 ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
   end

   // Overflow is judged on the captured value and only published together with the digits.
   always_ff @(posedge clk) begin
      if (reset) begin
         bin      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         digits   <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         bin      <= value;
         bcd      <= '0;
         cnt      <= CW'(BIN_WIDTH);
         ovf_pend <= 64'(value) >= LIMIT;
      end else if (state == ST_SHIFT) begin
         {bcd, bin} <= shifted;
         cnt        <= cnt - CW'(1);
         if (last) begin
            digits   <= shifted[BIN_WIDTH +: BW];
            overflow <= ovf_pend;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == DW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + DW'(1);
      end
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [6:0] dec;
      logic       lead;
      bcd_to_7seg u_dec (
         .digit (digits[4*i +: 4]),
         .seg   (dec)
      );
      assign lead = blank_leading && i != 0 && digits[BW-1:4*i] == '0;
      assign segments[7*i +: 7] = blink_en && phase ? SEG_BLANK
                                : overflow        ? SEG_DASH
                                : lead            ? SEG_BLANK
                                :                   dec;
   end

endmodule

// File: tb/tb_score_display_driver.sv
// tb_score_display_driver: directed checks of conversion latency, decode, blanking,
// overflow, ignored loads, reset abort and blink for a 4-digit display.
module tb_score_display_driver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [13:0] value = '0;
   logic        load = 1'b0;
   logic        ready;
   logic        blank_leading = 1'b0;
   logic        blink_en = 1'b0;
   logic        overflow;
   logic [27:0] segments;
   int          checks = 0;
   int          failures = 0;
   int          lat;
   int          n;

   always #5 clk = ~clk;

   score_display_driver #(
      .NUM_DIGITS (4),
      .BIN_WIDTH  (14),
      .BLINK_DIV  (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .value         (value),
      .load          (load),
      .ready         (ready),
      .blank_leading (blank_leading),
      .blink_en      (blink_en),
      .overflow      (overflow),
      .segments      (segments)
   );

   function automatic logic [27:0] s4(input logic [6:0] d3, d2, d1, d0);
      return {d3, d2, d1, d0};
   endfunction

   task automatic step(input int k = 1);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Holds load for one cycle, then scrambles value so only the accepted sample matters.
   task automatic start_load(input logic [13:0] v);
      value = v;
      load  = 1'b1;
      step();
      load  = 1'b0;
      value = 14'h3FFF;
   endtask

   task automatic wait_ready(output int c);
      c = 0;
      while (ready !== 1'b1 && c < 40) begin
         c++;
         step();
      end
   endtask

   initial begin
      step(2);
      reset = 1'b0;
      chk("rst_ready", ready, 1);
      chk("rst_ovf", overflow, 0);
      chk("rst_segs", segments, s4(7'h40, 7'h40, 7'h40, 7'h40));
      blank_leading = 1'b1;
      #1;
      chk("rst_segs_blank", segments, s4(7'h7F, 7'h7F, 7'h7F, 7'h40));

      blank_leading = 1'b0;
      start_load(14'd1234);
      chk("busy_1234", ready, 0);
      chk("hold_1234", segments, s4(7'h40, 7'h40, 7'h40, 7'h40));
      wait_ready(lat);
      chk("lat_1234", lat, 14);
      chk("segs_1234", segments, s4(7'h79, 7'h24, 7'h30, 7'h19));
      chk("ovf_1234", overflow, 0);

      blank_leading = 1'b1;
      start_load(14'd7);
      wait_ready(lat);
      chk("lat_7", lat, 14);
      chk("segs_7_blank", segments, s4(7'h7F, 7'h7F, 7'h7F, 7'h78));
      blank_leading = 1'b0;
      #1;
      chk("segs_7_noblank", segments, s4(7'h40, 7'h40, 7'h40, 7'h78));

      blank_leading = 1'b1;
      start_load(14'd10000);
      wait_ready(lat);
      chk("segs_10000", segments, s4(7'h3F, 7'h3F, 7'h3F, 7'h3F));
      chk("ovf_10000", overflow, 1);
      start_load(14'd9999);
      wait_ready(lat);
      chk("segs_9999", segments, s4(7'h10, 7'h10, 7'h10, 7'h10));
      chk("ovf_9999", overflow, 0);

      start_load(14'd42);
      step(2);
      start_load(14'd77);
      wait_ready(lat);
      chk("lat_42_tail", lat, 11);
      chk("segs_42", segments, s4(7'h7F, 7'h7F, 7'h19, 7'h24));
      step(2);
      chk("no_queue_ready", ready, 1);
      step(16);
      chk("segs_42_stable", segments, s4(7'h7F, 7'h7F, 7'h19, 7'h24));

      start_load(14'd5555);
      step(5);
      reset = 1'b1;
      step();
      chk("abort_ready", ready, 1);
      chk("abort_ovf", overflow, 0);
      chk("abort_segs", segments, s4(7'h7F, 7'h7F, 7'h7F, 7'h40));
      reset = 1'b0;
      step(20);
      chk("abort_no_commit", segments, s4(7'h7F, 7'h7F, 7'h7F, 7'h40));

      blank_leading = 1'b0;
      start_load(14'd8);
      wait_ready(lat);
      chk("segs_8", segments, s4(7'h40, 7'h40, 7'h40, 7'h00));
      blink_en = 1'b1;
      #1;
      n = 0;
      while (segments !== s4(7'h40, 7'h40, 7'h40, 7'h00) && n < 10) begin
         n++;
         step();
      end
      while (segments !== 28'hFFFFFFF && n < 20) begin
         n++;
         step();
      end
      chk("blink_sync", n < 20, 1);
      for (int k = 0; k < 4; k++) begin
         chk("blink_off", segments, 28'hFFFFFFF);
         step();
      end
      for (int k = 0; k < 4; k++) begin
         chk("blink_on", segments, s4(7'h40, 7'h40, 7'h40, 7'h00));
         step();
      end
      chk("blink_off2", segments, 28'hFFFFFFF);
      blink_en = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("blink_disabled", segments, s4(7'h40, 7'h40, 7'h40, 7'h00));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
